// File: rtl/pd_row_stream_decoder.sv
// pd_row_stream_decoder: consumes the pdShank pixel FIFO, rebuilds rows and frames,
// pairs each signal sample with its reset sample and streams out CDS pixels.
// Framing errors are counted and the decoder falls back to hunting for a frame start.
module pd_row_stream_decoder #(
    parameter int NCOL = 10,
    parameter int DW   = 10
) (
    input  logic                 clk_in,
    input  logic                 fsm_rst,
    input  logic                 fifo_empty,
    input  logic [15:0]          fifo_dout,
    output logic                 fifo_rd_en,
    input  logic [9:0]           numRows,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [9:0]           pix_row,
    output logic [3:0]           pix_col,
    output logic [DW-1:0]        pix_sig,
    output logic [DW-1:0]        pix_rst,
    output logic signed [DW:0]   pix_diff,
    output logic                 pix_sof,
    output logic                 pix_eof,
    output logic                 frame_done,
    output logic [9:0]           frameCount,
    output logic                 err_pulse,
    output logic [7:0]           err_count
);

    typedef enum logic [1:0] {SYNC, SIG, RST} state_t;

    state_t          state, state_next;
    logic [3:0]      col;
    logic [9:0]      row;
    logic [9:0]      numrows_l;
    logic [DW-1:0]   sig_buf [NCOL];

    logic [3:0]      w_col;
    logic            w_flag;
    logic            w_rsv;
    logic [DW-1:0]   w_data;
    logic            accept;
    logic            col_last;
    logic            row_last;
    logic            word_ok;
    logic            frame_start;
    logic            store_sig;
    logic            load_pix;
    logic            err_det;
    logic            handshake;

    // Reset sample minus signal sample, widened by one bit so it never wraps.
    function automatic logic signed [DW:0] cds_diff(input logic [DW-1:0] r, input logic [DW-1:0] s);
        return $signed({1'b0, r}) - $signed({1'b0, s});
    endfunction

    // Error counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_col     = fifo_dout[15:12];
    assign w_flag    = fifo_dout[11];
    assign w_rsv     = fifo_dout[10];
    assign w_data    = fifo_dout[DW-1:0];
    assign col_last  = (col == 4'(NCOL - 1));
    assign row_last  = (row == numrows_l - 10'd1);
    assign word_ok   = (w_col == col) && !w_rsv && (w_flag == (row == 10'd0));
    // Only the reset half is throttled by the output; signal words always drain.
    assign accept    = (state != RST) || !pix_valid || pix_ready;
    assign fifo_rd_en = !fifo_empty && accept;
    assign handshake = pix_valid && pix_ready;

    // State register.
    always_ff @(posedge clk_in or posedge fsm_rst) begin
        if (fsm_rst) state <= SYNC;
        else         state <= state_next;
    end

    // Next-state decode and per-word strobes.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        store_sig   = 1'b0;
        load_pix    = 1'b0;
        err_det     = 1'b0;
        case (state)
            SYNC: begin
                if (fifo_rd_en && w_col == 4'd0 && w_flag && !w_rsv && numRows != 10'd0) begin
                    frame_start = 1'b1;
                    state_next  = (NCOL == 1) ? RST : SIG;
                end
            end
            SIG: begin
                if (fifo_rd_en) begin
                    if (word_ok) begin
                        store_sig = 1'b1;
                        if (col_last) state_next = RST;
                    end else begin
                        err_det    = 1'b1;
                        state_next = SYNC;
                    end
                end
            end
            RST: begin
                if (fifo_rd_en) begin
                    if (word_ok) begin
                        load_pix = 1'b1;
                        if (col_last) state_next = row_last ? SYNC : SIG;
                    end else begin
                        err_det    = 1'b1;
                        state_next = SYNC;
                    end
                end
            end
            default: state_next = SYNC;
        endcase
    end

    // Row/column position within the frame and latched frame height.
    always_ff @(posedge clk_in or posedge fsm_rst) begin
        if (fsm_rst) begin
            col       <= '0;
            row       <= '0;
            numrows_l <= '0;
        end else if (frame_start) begin
            numrows_l <= numRows;
            row       <= '0;
            col       <= (NCOL == 1) ? 4'd0 : 4'd1;
        end else if (store_sig) begin
            col <= col_last ? 4'd0 : col + 4'd1;
        end else if (load_pix) begin
            if (col_last) begin
                col <= 4'd0;
                row <= row + 10'd1;
            end else begin
                col <= col + 4'd1;
            end
        end else if (err_det) begin
            col <= '0;
            row <= '0;
        end
    end

    // Signal-half sample buffer; contents only matter once the row has been filled.
    always_ff @(posedge clk_in) begin
        if (frame_start)    sig_buf[0]   <= w_data;
        else if (store_sig) sig_buf[col] <= w_data;
    end

    // Output pixel register: loads on a reset-word pop, holds until handshaken.
    always_ff @(posedge clk_in or posedge fsm_rst) begin
        if (fsm_rst) begin
            pix_valid <= 1'b0;
            pix_row   <= '0;
            pix_col   <= '0;
            pix_sig   <= '0;
            pix_rst   <= '0;
            pix_diff  <= '0;
            pix_sof   <= 1'b0;
            pix_eof   <= 1'b0;
        end else if (load_pix) begin
            pix_valid <= 1'b1;
            pix_row   <= row;
            pix_col   <= col;
            pix_sig   <= sig_buf[col];
            pix_rst   <= w_data;
            pix_diff  <= cds_diff(w_data, sig_buf[col]);
            pix_sof   <= (row == 10'd0) && (col == 4'd0);
            pix_eof   <= row_last && col_last;
        end else if (handshake) begin
            pix_valid <= 1'b0;
        end
    end

    // Frame completion and framing-error bookkeeping.
    always_ff @(posedge clk_in or posedge fsm_rst) begin
        if (fsm_rst) begin
            frame_done <= 1'b0;
            frameCount <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            frame_done <= handshake && pix_eof;
            if (handshake && pix_eof) frameCount <= frameCount + 10'd1;
            err_pulse <= err_det;
            if (err_det) err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_pd_row_stream_decoder.sv
// Bench for pd_row_stream_decoder: word streams are played into an FWFT FIFO model,
// a frame-position reference model predicts pixels/errors, a monitor scores the output.
module tb_pd_row_stream_decoder;

    localparam int NCOL = 10;
    localparam int DW   = 10;

    logic                clk = 1'b0;
    logic                fsm_rst;
    logic                fifo_empty;
    logic [15:0]         fifo_dout;
    logic                fifo_rd_en;
    logic [9:0]          num_rows;
    logic                pix_valid;
    logic                pix_ready;
    logic [9:0]          pix_row;
    logic [3:0]          pix_col;
    logic [DW-1:0]       pix_sig;
    logic [DW-1:0]       pix_rst;
    logic signed [DW:0]  pix_diff;
    logic                pix_sof;
    logic                pix_eof;
    logic                frame_done;
    logic [9:0]          frameCount;
    logic                err_pulse;
    logic [7:0]          err_count;

    pd_row_stream_decoder #(.NCOL(NCOL), .DW(DW)) dut (
        .clk_in(clk), .fsm_rst(fsm_rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .numRows(num_rows), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_row(pix_row), .pix_col(pix_col), .pix_sig(pix_sig), .pix_rst(pix_rst),
        .pix_diff(pix_diff), .pix_sof(pix_sof), .pix_eof(pix_eof), .frame_done(frame_done),
        .frameCount(frameCount), .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard and reference-model state.
    logic [46:0] exp_q[$];
    logic [15:0] stim[$];
    bit          in_frame = 0;
    int          pos = 0;
    int          nrows_m = 0;
    int          sbuf[NCOL];
    int          exp_err = 0;
    int          exp_errp = 0;
    int          got_errp = 0;
    int          exp_done = 0;
    int          got_done = 0;
    int          exp_fc = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int c, input bit f, input int d);
        return {c[3:0], f, 1'b0, d[9:0]};
    endfunction

    // Reference model: a frame is 2*NCOL*nrows words; position fixes the expected word.
    task automatic model_word(input logic [15:0] w);
        int c, d, ec, erow;
        bit f, r, rhalf;
        c = int'(w[15:12]); f = w[11]; r = w[10]; d = int'(w[9:0]);
        if (!in_frame) begin
            if (c == 0 && f && !r && num_rows != 0) begin
                in_frame = 1; nrows_m = int'(num_rows); sbuf[0] = d; pos = 1;
            end
        end else begin
            ec    = pos % NCOL;
            erow  = pos / (2 * NCOL);
            rhalf = ((pos / NCOL) % 2) == 1;
            if (c == ec && !r && f == (erow == 0)) begin
                if (!rhalf) sbuf[ec] = d;
                else exp_q.push_back({10'(erow), 4'(ec), 10'(sbuf[ec]), 10'(d), 11'(d - sbuf[ec]),
                                      (erow == 0 && ec == 0), (erow == nrows_m - 1 && ec == NCOL - 1)});
                pos++;
                if (pos == nrows_m * 2 * NCOL) in_frame = 0;
            end else begin
                in_frame = 0;
                if (exp_err < 255) exp_err++;
                exp_errp++;
            end
        end
    endtask

    function automatic int gen_data(input int dmode, input bit rhalf, input int c);
        case (dmode)
            0:       return rhalf ? 100 + c : c;
            2:       return rhalf ? 0 : 1023;
            3:       return rhalf ? 1023 : 0;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    task automatic add_frame(input int nrows, input int dmode, input int r0);
        for (int r = r0; r < nrows; r++)
            for (int h = 0; h < 2; h++)
                for (int c = 0; c < NCOL; c++)
                    stim.push_back(mk(c, r == 0, gen_data(dmode, h == 1, c)));
    endtask

    task automatic drive_ready(input int rmode);
        cyc++;
        case (rmode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = cyc[0];
            default: pix_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic play(input int rmode, input bit gaps, input bit drain);
        logic [15:0] w;
        int guard;
        while (stim.size() > 0) begin
            w = stim.pop_front();
            guard = 0;
            forever begin
                @(negedge clk);
                drive_ready(rmode);
                if (gaps && $urandom_range(0, 3) == 0) fifo_empty = 1'b1;
                else begin fifo_empty = 1'b0; fifo_dout = w; end
                #1;
                if (!fifo_empty && fifo_rd_en) begin model_word(w); break; end
                guard++;
                if (guard > 200) begin check("pop_timeout", 0, 1); break; end
            end
        end
        @(posedge clk); #1;
        fifo_empty = 1'b1;
        if (drain) begin
            guard = 0;
            forever begin
                @(negedge clk);
                drive_ready(rmode);
                #1;
                if (exp_q.size() == 0 && !pix_valid) break;
                guard++;
                if (guard > 500) begin check("drain_timeout", 0, 1); break; end
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic end_check(input string tag);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
        check({tag, "_frameCount"}, 64'(frameCount), 64'(exp_fc));
        check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
        check({tag, "_frame_done_pulses"}, 64'(got_done), 64'(exp_done));
        check({tag, "_err_pulses"}, 64'(got_errp), 64'(exp_errp));
    endtask

    // Monitor: scores handshaken pixels, checks stability while stalled, counts pulses.
    logic [46:0] held;
    bit          stalled = 0;
    always begin
        logic [46:0] cur, e;
        @(negedge clk);
        #2;
        cur = {pix_row, pix_col, pix_sig, pix_rst, pix_diff, pix_sof, pix_eof};
        if (pix_valid) begin
            if (stalled) check("stall_stable", 64'(cur), 64'(held));
            if (pix_ready) begin
                if (exp_q.size() == 0) check("unexpected_pixel", 64'(cur), 0);
                else begin
                    e = exp_q.pop_front();
                    check("pixel", 64'(cur), 64'(e));
                    if (e[0]) begin exp_done++; exp_fc = (exp_fc + 1) % 1024; end
                end
                stalled = 0;
            end else begin
                held = cur;
                stalled = 1;
            end
        end else stalled = 0;
        if (frame_done) got_done++;
        if (err_pulse) got_errp++;
    end

    initial begin
        fsm_rst = 1'b1; fifo_empty = 1'b1; fifo_dout = '0; pix_ready = 1'b0; num_rows = 10'd2;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pix_valid", 64'(pix_valid), 0);
        check("rst_pix_fields", 64'({pix_row, pix_col, pix_sig, pix_rst, pix_diff, pix_sof, pix_eof}), 0);
        check("rst_frame_done", 64'(frame_done), 0);
        check("rst_frameCount", 64'(frameCount), 0);
        check("rst_err", 64'({err_pulse, err_count}), 0);
        fsm_rst = 1'b0;

        // 1: clean two-row ramp frame, always ready
        num_rows = 10'd2;
        add_frame(2, 0, 0);
        play(0, 0, 1);
        end_check("t1");
        check("t1_frames", 64'(frameCount), 1);

        // 2: same frame, toggling ready and FIFO gaps
        add_frame(2, 0, 0);
        play(1, 1, 1);
        end_check("t2");

        // 3: row-1 signal col 5 replaced by col 6, then a clean frame
        add_frame(2, 0, 0);
        stim[2 * NCOL + 5] = mk(6, 0, 5);
        add_frame(2, 1, 0);
        play(2, 1, 1);
        end_check("t3");
        check("t3_err_count", 64'(err_count), 1);

        // 4: stream joins mid-frame, lone row-0 reset half, then clean frame
        num_rows = 10'd5;
        add_frame(5, 0, 3);
        for (int c = 0; c < NCOL; c++) stim.push_back(mk(c, 1, 100 + c));
        add_frame(5, 0, 1);
        add_frame(5, 1, 0);
        play(0, 1, 1);
        end_check("t4");

        // 5: full-scale differences in both directions
        num_rows = 10'd1;
        add_frame(1, 2, 0);
        add_frame(1, 3, 0);
        play(2, 0, 1);
        end_check("t5");

        // numRows=0: frame starts are ignored
        num_rows = 10'd0;
        add_frame(1, 1, 0);
        play(0, 1, 1);
        end_check("t5z");

        // 6: reset during a stalled reset-half pixel
        num_rows = 10'd3;
        add_frame(2, 1, 0);
        for (int c = 0; c < NCOL; c++) stim.push_back(mk(c, 0, c));
        for (int c = 0; c < 4; c++) stim.push_back(mk(c, 0, 500 + c));
        play(0, 0, 0);
        @(negedge clk);
        pix_ready = 1'b0;
        @(negedge clk);
        #1;
        check("t6_stalled_valid", 64'(pix_valid), 1);
        fsm_rst = 1'b1;
        exp_q.delete(); in_frame = 0; exp_err = 0; exp_fc = 0;
        #2;
        check("t6_rst_valid", 64'(pix_valid), 0);
        check("t6_rst_fields", 64'({pix_row, pix_col, pix_sig, pix_rst, pix_diff, pix_eof}), 0);
        check("t6_rst_counts", 64'({frameCount, err_count}), 0);
        @(negedge clk);
        fsm_rst = 1'b0;
        add_frame(3, 1, 0);
        play(1, 1, 1);
        end_check("t6");
        check("t6_frames", 64'(frameCount), 1);

        // 7: random frames with occasional corrupted words
        for (int k = 0; k < 6; k++) begin
            num_rows = 10'($urandom_range(1, 3));
            add_frame(int'(num_rows), 1, 0);
            if ($urandom_range(0, 1) == 1) begin
                int i;
                i = int'($urandom_range(0, stim.size() - 1));
                stim[i] = stim[i] ^ (16'h0400 << $urandom_range(0, 5));
            end
            play(2, 1, 1);
            end_check("t7");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
